// File: rtl/barrel_shifter_arbiter_if.sv
// Request/response bundle between two operation sources and the shared shifter arbiter.
// The master side drives requests and rsp_ready. The slave side is the arbiter.
interface barrel_shifter_arbiter_if;
    logic       a_valid;
    logic       a_ready;
    logic       a_select;
    logic       a_direction;
    logic [1:0] a_shift_value;
    logic [3:0] a_din;
    logic       b_valid;
    logic       b_ready;
    logic       b_select;
    logic       b_direction;
    logic [1:0] b_shift_value;
    logic [3:0] b_din;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [3:0] rsp_dout;
    logic [7:0] ops_done;

    modport master (
        output a_valid, a_select, a_direction, a_shift_value, a_din,
        output b_valid, b_select, b_direction, b_shift_value, b_din,
        output rsp_ready,
        input  a_ready, b_ready, rsp_valid, rsp_id, rsp_dout, ops_done
    );

    modport slave (
        input  a_valid, a_select, a_direction, a_shift_value, a_din,
        input  b_valid, b_select, b_direction, b_shift_value, b_din,
        input  rsp_ready,
        output a_ready, b_ready, rsp_valid, rsp_id, rsp_dout, ops_done
    );
endinterface

// File: rtl/barrel_shifter_arbiter.sv
// Round-robin arbiter sharing one 4-bit shifter between A and B. Result is registered: rsp_valid one cycle after the grant.
// Requests stall (ready low) while a response waits on rsp_ready; at most one op per two cycles.
module barrel_shifter (
    input  logic       select,
    input  logic       direction,
    input  logic [1:0] shift_value,
    input  logic [3:0] din,
    output logic [3:0] dout
);
    always_comb begin
        dout = din;
        unique case ({select, direction})
            2'b00:   dout = din >> shift_value;
            2'b01:   dout = din << shift_value;
            2'b10:   dout = 4'({din, din} >> shift_value);
            default: dout = 4'({din, din} >> (3'd4 - {1'b0, shift_value}));
        endcase
    end
endmodule

module barrel_shifter_arbiter #(
    parameter bit PRIORITY_INIT = 1'b0
) (
    input logic                     clk,
    input logic                     rst,
    barrel_shifter_arbiter_if.slave bus
);
    typedef enum logic {IDLE, RESP} state_t;

    typedef struct packed {
        logic       select;
        logic       direction;
        logic [1:0] shift_value;
        logic [3:0] din;
    } op_t;

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;
    logic       grant;
    logic       accept;
    logic       rsp_fire;
    op_t        a_op;
    op_t        b_op;
    op_t        sh_op;
    logic [3:0] sh_dout;
    logic       rsp_id;
    logic [3:0] rsp_dout;
    logic [7:0] ops_done;

    assign a_op = '{select: bus.a_select, direction: bus.a_direction,
                    shift_value: bus.a_shift_value, din: bus.a_din};
    assign b_op = '{select: bus.b_select, direction: bus.b_direction,
                    shift_value: bus.b_shift_value, din: bus.b_din};

    // With no request pending grant stays 0, so A's fields feed the idle shifter.
    always_comb begin
        grant = 1'b0;
        if (bus.a_valid && bus.b_valid)
            grant = ~last_grant;
        else if (bus.b_valid)
            grant = 1'b1;
        sh_op = grant ? b_op : a_op;
    end

    barrel_shifter u_shifter (
        .select      (sh_op.select),
        .direction   (sh_op.direction),
        .shift_value (sh_op.shift_value),
        .din         (sh_op.din),
        .dout        (sh_dout)
    );

    always_comb begin
        state_nxt     = state;
        bus.a_ready   = 1'b0;
        bus.b_ready   = 1'b0;
        bus.rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                bus.a_ready = bus.a_valid && !grant;
                bus.b_ready = bus.b_valid && grant;
                if (bus.a_valid || bus.b_valid)
                    state_nxt = RESP;
            end
            default: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready)
                    state_nxt = IDLE;
            end
        endcase
    end

    assign accept   = bus.a_ready || bus.b_ready;
    assign rsp_fire = bus.rsp_valid && bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= ~PRIORITY_INIT;
            rsp_id     <= 1'b0;
            rsp_dout   <= 4'b0000;
            ops_done   <= 8'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rsp_dout   <= sh_dout;
                rsp_id     <= grant;
                last_grant <= grant;
            end
            if (rsp_fire)
                ops_done <= ops_done + 8'd1;
        end
    end

    assign bus.rsp_id   = rsp_id;
    assign bus.rsp_dout = rsp_dout;
    assign bus.ops_done = ops_done;
endmodule

// File: tb/tb_barrel_shifter_arbiter.sv
// Directed bench for barrel_shifter_arbiter with a per-cycle reference model and literal spot checks.
module tb_barrel_shifter_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    barrel_shifter_arbiter_if bus();

    barrel_shifter_arbiter #(.PRIORITY_INIT(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    bit         m_busy;
    bit         m_id;
    bit         m_last;
    logic [3:0] m_dout;
    int         m_ops;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit-by-bit reference: output bit i takes input bit i+n (right) or i-n (left).
    function automatic logic [3:0] ref_op(input bit sel, input bit dir, input int n, input logic [3:0] din);
        logic [3:0] r;
        int src;
        r = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            src = dir ? i - n : i + n;
            if (sel)
                r[i] = din[(src + 4) % 4];
            else if (src >= 0 && src < 4)
                r[i] = din[src];
        end
        return r;
    endfunction

    function automatic bit pick(input bit av, input bit bv, input bit last);
        if (av && bv) return !last;
        return bv;
    endfunction

    always @(posedge clk) begin
        bit g;
        if (rst) begin
            m_busy = 1'b0; m_id = 1'b0; m_dout = 4'b0000; m_ops = 0; m_last = 1'b1;
        end else if (m_busy) begin
            if (bus.rsp_ready) begin
                m_busy = 1'b0;
                m_ops  = (m_ops + 1) % 256;
            end
        end else if (bus.a_valid || bus.b_valid) begin
            g = pick(bus.a_valid, bus.b_valid, m_last);
            m_id   = g;
            m_last = g;
            m_dout = g ? ref_op(bus.b_select, bus.b_direction, int'(bus.b_shift_value), bus.b_din)
                       : ref_op(bus.a_select, bus.a_direction, int'(bus.a_shift_value), bus.a_din);
            m_busy = 1'b1;
        end
    end

    always @(negedge clk) begin
        bit g;
        bit any;
        if (chk_en) begin
            g   = pick(bus.a_valid, bus.b_valid, m_last);
            any = bus.a_valid || bus.b_valid;
            chk("model_rsp_valid", 32'(bus.rsp_valid), 32'(m_busy));
            chk("model_a_ready", 32'(bus.a_ready), 32'(!m_busy && any && !g));
            chk("model_b_ready", 32'(bus.b_ready), 32'(!m_busy && any && g));
            chk("model_ops_done", 32'(bus.ops_done), 32'(m_ops));
            if (m_busy) begin
                chk("model_rsp_id", 32'(bus.rsp_id), 32'(m_id));
                chk("model_rsp_dout", 32'(bus.rsp_dout), 32'(m_dout));
            end
        end
    end

    task automatic drive(input bit who, input bit sel, input bit dir, input logic [1:0] sv, input logic [3:0] din);
        if (who) begin
            bus.b_select = sel; bus.b_direction = dir; bus.b_shift_value = sv; bus.b_din = din; bus.b_valid = 1'b1;
        end else begin
            bus.a_select = sel; bus.a_direction = dir; bus.a_shift_value = sv; bus.a_din = din; bus.a_valid = 1'b1;
        end
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) return;
        end
        chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic single(input bit who, input bit sel, input bit dir, input logic [1:0] sv,
                          input logic [3:0] din, input logic [3:0] exp);
        drive(who, sel, dir, sv, din);
        @(negedge clk);
        chk("single_ready", 32'(who ? bus.b_ready : bus.a_ready), 32'd1);
        @(posedge clk); #1;
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        wait_rsp();
        chk("single_rsp_id", 32'(bus.rsp_id), 32'(who));
        chk("single_rsp_dout", 32'(bus.rsp_dout), 32'(exp));
        @(posedge clk); #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] ops_before;
        bus.a_valid = 1'b0; bus.a_select = 1'b0; bus.a_direction = 1'b0; bus.a_shift_value = 2'd0; bus.a_din = 4'd0;
        bus.b_valid = 1'b0; bus.b_select = 1'b0; bus.b_direction = 1'b0; bus.b_shift_value = 2'd0; bus.b_din = 4'd0;
        bus.rsp_ready = 1'b1;

        rst = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("reset_rsp_dout", 32'(bus.rsp_dout), 32'd0);
        chk("reset_ops_done", 32'(bus.ops_done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // A alone, then B sequence
        single(1'b0, 1'b1, 1'b0, 2'd1, 4'b1011, 4'b1101);
        chk("a_alone_ops_done", 32'(bus.ops_done), 32'd1);
        single(1'b1, 1'b0, 1'b0, 2'd3, 4'b1000, 4'b0001);
        single(1'b1, 1'b0, 1'b1, 2'd2, 4'b0001, 4'b0100);
        single(1'b1, 1'b1, 1'b1, 2'd3, 4'b1011, 4'b1101);
        single(1'b1, 1'b1, 1'b0, 2'd2, 4'b1011, 4'b1110);
        chk("b_seq_ops_done", 32'(bus.ops_done), 32'd5);

        // Tie after reset: A first, then strict alternation
        reset_pulse();
        drive(1'b0, 1'b1, 1'b0, 2'd1, 4'b1011);
        drive(1'b1, 1'b0, 1'b1, 2'd1, 4'b0001);
        for (int i = 0; i < 8; i++) begin
            wait_rsp();
            chk("tie_rsp_id", 32'(bus.rsp_id), 32'(i % 2));
            chk("tie_rsp_dout", 32'(bus.rsp_dout), (i % 2 == 1) ? 32'h2 : 32'hd);
            @(posedge clk); #1;
        end
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        chk("tie_ops_done", 32'(bus.ops_done), 32'd8);

        // Backpressure with B waiting
        bus.rsp_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'd1, 4'b1100);
        @(posedge clk); #1;
        bus.a_valid = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 2'd1, 4'b0101);
        wait_rsp();
        ops_before = bus.ops_done;
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_dout", 32'(bus.rsp_dout), 32'h6);
            chk("bp_rsp_id", 32'(bus.rsp_id), 32'd0);
            chk("bp_a_ready", 32'(bus.a_ready), 32'd0);
            chk("bp_b_ready", 32'(bus.b_ready), 32'd0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_one_handshake", 32'(bus.ops_done), 32'(ops_before + 8'd1));
        chk("bp_released_valid", 32'(bus.rsp_valid), 32'd0);
        wait_rsp();
        bus.b_valid = 1'b0;
        chk("bp_b_rsp_id", 32'(bus.rsp_id), 32'd1);
        chk("bp_b_rsp_dout", 32'(bus.rsp_dout), 32'ha);
        @(posedge clk); #1;

        // Reset in RESP overrides a simultaneous response handshake
        drive(1'b0, 1'b0, 1'b1, 2'd1, 4'b0011);
        @(posedge clk); #1;
        bus.a_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_resp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_resp_ops_done", 32'(bus.ops_done), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 2'd1, 4'b1000);
        drive(1'b1, 1'b1, 1'b0, 2'd1, 4'b0001);
        wait_rsp();
        bus.a_valid = 1'b0;
        chk("rst_tie_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_tie_dout", 32'(bus.rsp_dout), 32'h4);
        wait_rsp();
        bus.b_valid = 1'b0;
        chk("rst_tie2_id", 32'(bus.rsp_id), 32'd1);
        chk("rst_tie2_dout", 32'(bus.rsp_dout), 32'h8);
        @(posedge clk); #1;

        // Zero shift passes data for every op
        for (int c = 0; c < 4; c++)
            single(1'b0, bit'(c >> 1), bit'(c & 1), 2'd0, 4'b1010, 4'b1010);

        // ops_done wrap
        reset_pulse();
        drive(1'b0, 1'b0, 1'b1, 2'd1, 4'b0001);
        for (int k = 1; k <= 256; k++) begin
            wait_rsp();
            @(posedge clk); #1;
            if (k == 255) chk("wrap_255", 32'(bus.ops_done), 32'd255);
            if (k == 256) begin
                bus.a_valid = 1'b0;
                chk("wrap_0", 32'(bus.ops_done), 32'd0);
            end
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
